ads8321_sampler_ctrl: RTL

//  Sequences the ADS8321 serial ADC driver: issues ad_start pulses from a programmable sample-period timer.

---
 rtl/ads8321_pkg.sv | 19 +
 rtl/ads8321_period_timer.sv | 28 ++
 rtl/ads8321_sampler_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ads8321_pkg.sv
// Shared types and constants for the ADS8321 sampling path.
package ads8321_pkg;

  localparam int unsigned AD_WIDTH = 16;
  localparam int unsigned AD_CYCLE = 21;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    CAPT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [AD_WIDTH-1:0] data;
    logic                last;
  } smp_t;

endpackage

// File: rtl/ads8321_period_timer.sv
// Free-running sample-period timer; restart forces a tick and realigns the count.
module ads8321_period_timer #(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                restart,
  input  logic [PERIOD_W-1:0] eff_period,
  output logic                tick_c
);

  logic [PERIOD_W-1:0] cnt;
  logic                at_end;

  assign at_end = (cnt == eff_period - PERIOD_W'(1));
  assign tick_c = en & (restart | at_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (tick_c) cnt <= '0;
      else        cnt <= cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/ads8321_sampler_ctrl.sv
// Paces ADS8321 conversions, supervises them with a timeout and hands samples
// downstream through a single valid/ready holding register.
module ads8321_sampler_ctrl
  import ads8321_pkg::*;
#(
  parameter int unsigned PERIOD_W   = 16,
  parameter int unsigned BURST_W    = 8,
  parameter int unsigned MIN_PERIOD = 24,
  parameter int unsigned TIMEOUT    = 32,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [BURST_W-1:0]  cfg_burst,
  output logic                ad_start,
  input  logic                ad_busy,
  input  logic                ad_dval,
  input  logic [AD_WIDTH-1:0] ad_data,
  output logic [AD_WIDTH-1:0] smp_data,
  output logic                smp_valid,
  input  logic                smp_ready,
  output logic                smp_last,
  output logic                burst_done,
  output logic                err_timeout,
  output logic [CNT_W-1:0]    ovr_cnt,
  output logic [CNT_W-1:0]    drop_cnt
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT);

  state_t              state, state_nxt;
  logic                en_q;
  logic                en_rise;
  logic [PERIOD_W-1:0] per_q;
  logic [BURST_W-1:0]  burst_q;
  logic [BURST_W-1:0]  bcnt;
  logic                done_q;
  logic [TMO_W-1:0]    tmo;
  smp_t                smp_q;
  logic                tick_c;
  logic                cap_c;
  logic                is_last_c;
  logic                tmo_hit_c;
  logic                blocked_c;
  logic                ovr_c;

  assign en_rise   = en & ~en_q;
  assign cap_c     = (state == WAIT) & ad_dval;
  assign tmo_hit_c = (state == WAIT) & ~ad_dval & (tmo == TMO_W'(TIMEOUT - 1));
  assign is_last_c = (burst_q != '0) & (BURST_W'(bcnt + BURST_W'(1)) == burst_q);
  // a fresh enable reopens the burst in the same cycle it forces its tick
  assign blocked_c = done_q & ~en_rise;
  assign ovr_c     = tick_c & ~blocked_c & ((state != IDLE) | ad_busy);

  assign smp_data = smp_q.data;
  assign smp_last = smp_q.last;

  ads8321_period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .restart    (en_rise),
    .eff_period (per_q),
    .tick_c     (tick_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick_c & ~blocked_c & ~ad_busy) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT: begin
        if (ad_dval)        state_nxt = CAPT;
        else if (tmo_hit_c) state_nxt = IDLE;
      end
      CAPT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q        <= 1'b0;
      per_q       <= '0;
      burst_q     <= '0;
      bcnt        <= '0;
      done_q      <= 1'b0;
      tmo         <= '0;
      smp_q       <= '0;
      smp_valid   <= 1'b0;
      ad_start    <= 1'b0;
      burst_done  <= 1'b0;
      err_timeout <= 1'b0;
      ovr_cnt     <= '0;
      drop_cnt    <= '0;
    end else begin
      en_q       <= en;
      ad_start   <= (state_nxt == START);
      burst_done <= cap_c & is_last_c;

      if (state == START)     tmo <= '0;
      else if (state == WAIT) tmo <= tmo + TMO_W'(1);

      if (tmo_hit_c) err_timeout <= 1'b1;

      if (ovr_c && ovr_cnt != '1) ovr_cnt <= ovr_cnt + CNT_W'(1);

      // a held sample wins over a new one unless it is being accepted now
      if (cap_c) begin
        if (burst_q != '0) begin
          bcnt <= bcnt + BURST_W'(1);
          if (is_last_c) done_q <= 1'b1;
        end
        if (smp_valid && !smp_ready) begin
          if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
        end else begin
          smp_q.data <= ad_data;
          smp_q.last <= is_last_c;
          smp_valid  <= 1'b1;
        end
      end else if (smp_valid && smp_ready) begin
        smp_valid <= 1'b0;
      end

      if (en_rise) begin
        per_q       <= (cfg_period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : cfg_period;
        burst_q     <= cfg_burst;
        bcnt        <= '0;
        done_q      <= 1'b0;
        err_timeout <= 1'b0;
      end
    end
  end

endmodule
